// File: rtl/ula_pkg.sv
// Shared constants for the ALU control block: ALU op codes, MIPS opcode and
// funct values, operand mux select codes and the controller state encoding.
package ula_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    // ALU operation codes
    localparam logic [4:0] OP_SLL  = 5'd0;
    localparam logic [4:0] OP_SRL  = 5'd1;
    localparam logic [4:0] OP_SRA  = 5'd2;
    localparam logic [4:0] OP_SLLV = 5'd3;
    localparam logic [4:0] OP_SRLV = 5'd4;
    localparam logic [4:0] OP_SRAV = 5'd5;
    localparam logic [4:0] OP_ADD  = 5'd6;
    localparam logic [4:0] OP_SUB  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NOR  = 5'd11;
    localparam logic [4:0] OP_SLT  = 5'd12;
    localparam logic [4:0] OP_SLTU = 5'd13;
    localparam logic [4:0] OP_LUI  = 5'd14;

    // MIPS primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Operand mux selects
    localparam logic [1:0] IN1_RT   = 2'b00;
    localparam logic [1:0] IN1_SIMM = 2'b01;
    localparam logic [1:0] IN1_ZIMM = 2'b10;
    localparam logic       IN2_RS    = 1'b0;
    localparam logic       IN2_SHAMT = 1'b1;

endpackage

// File: rtl/ula_ctrl_dec.sv
// Combinational instruction decoder: maps opcode/funct/rt/rd to the ALU
// operation, operand mux selects, write-back register and an illegal flag.
module ula_ctrl_dec
    import ula_pkg::*;
#(
    parameter bit ALLOW_UNSIGNED_ALIAS = 1'b1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output logic [4:0] ula_op,
    output logic [1:0] in1_sel,
    output logic       in2_sel,
    output logic [4:0] wb_addr,
    output logic       illegal
);

    // Table decode; anything not listed is flagged illegal
    always_comb begin
        ula_op  = OP_SLL;
        in1_sel = IN1_RT;
        in2_sel = IN2_RS;
        wb_addr = rd;
        illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                wb_addr = rd;
                case (funct)
                    FN_SLL:  begin ula_op = OP_SLL; in2_sel = IN2_SHAMT; end
                    FN_SRL:  begin ula_op = OP_SRL; in2_sel = IN2_SHAMT; end
                    FN_SRA:  begin ula_op = OP_SRA; in2_sel = IN2_SHAMT; end
                    FN_SLLV: ula_op = OP_SLLV;
                    FN_SRLV: ula_op = OP_SRLV;
                    FN_SRAV: ula_op = OP_SRAV;
                    FN_ADD:  ula_op = OP_ADD;
                    FN_ADDU: begin
                        ula_op  = OP_ADD;
                        illegal = !ALLOW_UNSIGNED_ALIAS;
                    end
                    FN_SUB:  ula_op = OP_SUB;
                    FN_SUBU: begin
                        ula_op  = OP_SUB;
                        illegal = !ALLOW_UNSIGNED_ALIAS;
                    end
                    FN_AND:  ula_op = OP_AND;
                    FN_OR:   ula_op = OP_OR;
                    FN_XOR:  ula_op = OP_XOR;
                    FN_NOR:  ula_op = OP_NOR;
                    FN_SLT:  ula_op = OP_SLT;
                    FN_SLTU: ula_op = OP_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_ADDI:  begin ula_op = OP_ADD;  in1_sel = IN1_SIMM; wb_addr = rt; end
            OPC_ADDIU: begin
                ula_op  = OP_ADD;
                in1_sel = IN1_SIMM;
                wb_addr = rt;
                illegal = !ALLOW_UNSIGNED_ALIAS;
            end
            OPC_SLTI:  begin ula_op = OP_SLT;  in1_sel = IN1_SIMM; wb_addr = rt; end
            OPC_SLTIU: begin ula_op = OP_SLTU; in1_sel = IN1_SIMM; wb_addr = rt; end
            OPC_ANDI:  begin ula_op = OP_AND;  in1_sel = IN1_ZIMM; wb_addr = rt; end
            OPC_ORI:   begin ula_op = OP_OR;   in1_sel = IN1_ZIMM; wb_addr = rt; end
            OPC_XORI:  begin ula_op = OP_XOR;  in1_sel = IN1_ZIMM; wb_addr = rt; end
            OPC_LUI:   begin ula_op = OP_LUI;  in1_sel = IN1_ZIMM; wb_addr = rt; end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ula_ctrl.sv
// ALU controller: accepts one MIPS instruction at a time and sequences it
// through IDLE -> DECODE -> EXEC -> WB, driving ALU op/mux selects, an exec
// strobe and a register write-back strobe.
module ula_ctrl
    import ula_pkg::*;
#(
    parameter bit ALLOW_UNSIGNED_ALIAS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  shamt,
    output logic [15:0] imm,
    output logic [4:0]  ula_op,
    output logic [1:0]  in1_sel,
    output logic        in2_sel,
    output logic        exec,
    output logic        reg_write,
    output logic [4:0]  wb_addr,
    output logic        illegal
);

    state_t     state;
    state_t     state_next;
    logic [5:0] opcode;

    logic [4:0] dec_ula_op;
    logic [1:0] dec_in1_sel;
    logic       dec_in2_sel;
    logic [4:0] dec_wb_addr;
    logic       dec_illegal;

    // funct and rd live inside the latched immediate field
    ula_ctrl_dec #(
        .ALLOW_UNSIGNED_ALIAS(ALLOW_UNSIGNED_ALIAS)
    ) u_dec (
        .opcode  (opcode),
        .funct   (imm[5:0]),
        .rt      (rt_addr),
        .rd      (imm[15:11]),
        .ula_op  (dec_ula_op),
        .in1_sel (dec_in1_sel),
        .in2_sel (dec_in2_sel),
        .wb_addr (dec_wb_addr),
        .illegal (dec_illegal)
    );

    assign instr_ready = (state == S_IDLE);

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; an illegal instruction occupies the EXEC slot with
    // exec suppressed (illegal pulses instead) and then returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (instr_valid) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = illegal ? S_IDLE : S_WB;
            S_WB:     state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Field latches, registered decode results and one-cycle strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode    <= '0;
            rs_addr   <= '0;
            rt_addr   <= '0;
            shamt     <= '0;
            imm       <= '0;
            ula_op    <= '0;
            in1_sel   <= '0;
            in2_sel   <= '0;
            wb_addr   <= '0;
            exec      <= 1'b0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            exec      <= 1'b0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        opcode  <= instr[31:26];
                        rs_addr <= instr[25:21];
                        rt_addr <= instr[20:16];
                        shamt   <= instr[10:6];
                        imm     <= instr[15:0];
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        illegal <= 1'b1;
                    end else begin
                        ula_op  <= dec_ula_op;
                        in1_sel <= dec_in1_sel;
                        in2_sel <= dec_in2_sel;
                        wb_addr <= dec_wb_addr;
                        exec    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!illegal && (wb_addr != 5'd0)) reg_write <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_ctrl.sv
// Self-checking bench for ula_ctrl: two instances (unsigned alias on/off)
// driven with the same directed and random instruction stream and compared
// cycle by cycle against a table-driven reference decoder.
module tb_ula_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;

    typedef struct packed {
        logic        ready;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [4:0]  op;
        logic [1:0]  in1;
        logic        in2;
        logic        exec;
        logic        rw;
        logic [4:0]  wb;
        logic        ill;
    } obs_t;

    typedef struct {
        bit legal;
        int op;
        int in1;
        int in2;
        int wb;
    } model_t;

    logic        rdy0, rdy1, in2_0, in2_1, ex0, ex1, rw0, rw1, il0, il1;
    logic [4:0]  rs0, rs1, rt0, rt1, sh0, sh1, op0, op1, wb0, wb1;
    logic [15:0] im0, im1;
    logic [1:0]  in1_0, in1_1;
    obs_t        o0, o1;

    int passed = 0;
    int total  = 0;

    int rtab[int];
    int itab_op[int];
    int itab_sel[int];

    always #5 clk = ~clk;

    ula_ctrl #(.ALLOW_UNSIGNED_ALIAS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(rdy0), .rs_addr(rs0), .rt_addr(rt0), .shamt(sh0), .imm(im0),
        .ula_op(op0), .in1_sel(in1_0), .in2_sel(in2_0), .exec(ex0),
        .reg_write(rw0), .wb_addr(wb0), .illegal(il0)
    );

    ula_ctrl #(.ALLOW_UNSIGNED_ALIAS(1'b1)) dut1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(rdy1), .rs_addr(rs1), .rt_addr(rt1), .shamt(sh1), .imm(im1),
        .ula_op(op1), .in1_sel(in1_1), .in2_sel(in2_1), .exec(ex1),
        .reg_write(rw1), .wb_addr(wb1), .illegal(il1)
    );

    assign o0 = {rdy0, rs0, rt0, sh0, im0, op0, in1_0, in2_0, ex0, rw0, wb0, il0};
    assign o1 = {rdy1, rs1, rt1, sh1, im1, op1, in1_1, in2_1, ex1, rw1, wb1, il1};

    function automatic obs_t get_obs(input int d);
        return (d == 0) ? o0 : o1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    endtask

    // Reference decode straight from the opcode/funct tables
    function automatic model_t ref_dec(input logic [31:0] ins, input bit alias_ok);
        model_t m;
        int opc = int'(ins[31:26]);
        int fn  = int'(ins[5:0]);
        m.legal = 0; m.op = 0; m.in1 = 0; m.in2 = 0; m.wb = 0;
        if (opc == 0) begin
            if (rtab.exists(fn) && (alias_ok || (fn != 'h21 && fn != 'h23))) begin
                m.legal = 1;
                m.op    = rtab[fn];
                m.in1   = 0;
                m.in2   = (fn == 'h00 || fn == 'h02 || fn == 'h03) ? 1 : 0;
                m.wb    = int'(ins[15:11]);
            end
        end else if (itab_op.exists(opc) && (alias_ok || opc != 'h09)) begin
            m.legal = 1;
            m.op    = itab_op[opc];
            m.in1   = itab_sel[opc];
            m.in2   = 0;
            m.wb    = int'(ins[20:16]);
        end
        return m;
    endfunction

    // Issue one instruction on both instances and follow it through its slots
    task automatic issue(input logic [31:0] ins);
        model_t m[2];
        obs_t   o;
        int     w;
        m[0] = ref_dec(ins, 1'b0);
        m[1] = ref_dec(ins, 1'b1);
        w = 0;
        while (!(rdy0 && rdy1) && w < 10) begin
            step();
            w++;
        end
        chk("ready_wait", 0, {63'd0, rdy0 && rdy1}, 64'd1);
        instr_valid = 1'b1;
        instr       = ins;
        step();                                   // N+1
        instr = $urandom;                         // must be ignored while busy
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("dec_ready", d, 64'(o.ready), 64'd0);
            chk("rs_addr",   d, 64'(o.rs),    64'(ins[25:21]));
            chk("rt_addr",   d, 64'(o.rt),    64'(ins[20:16]));
            chk("shamt",     d, 64'(o.shamt), 64'(ins[10:6]));
            chk("imm",       d, 64'(o.imm),   64'(ins[15:0]));
            chk("dec_pulses", d, {61'd0, o.exec, o.rw, o.ill}, 64'd0);
        end
        step();                                   // N+2
        instr = $urandom;
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("exec_ready", d, 64'(o.ready), 64'd0);
            if (m[d].legal) begin
                chk("exec",    d, {62'd0, o.exec, o.ill}, 64'd2);
                chk("ula_op",  d, 64'(o.op),  64'(m[d].op));
                chk("in1_sel", d, 64'(o.in1), 64'(m[d].in1));
                chk("in2_sel", d, 64'(o.in2), 64'(m[d].in2));
                chk("exec_rw", d, 64'(o.rw),  64'd0);
            end else begin
                chk("illegal", d, {61'd0, o.exec, o.rw, o.ill}, 64'd1);
            end
        end
        step();                                   // N+3
        instr_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            if (m[d].legal) begin
                chk("wb_ready",  d, 64'(o.ready), 64'd0);
                chk("reg_write", d, 64'(o.rw), (m[d].wb != 0) ? 64'd1 : 64'd0);
                chk("wb_addr",   d, 64'(o.wb), 64'(m[d].wb));
                chk("op_hold",   d, 64'(o.op), 64'(m[d].op));
                chk("wb_pulses", d, {62'd0, o.exec, o.ill}, 64'd0);
            end else begin
                chk("ill_ready",  d, 64'(o.ready), 64'd1);
                chk("ill_after",  d, {61'd0, o.exec, o.rw, o.ill}, 64'd0);
            end
        end
        step();                                   // N+4
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("idle_ready",  d, 64'(o.ready), 64'd1);
            chk("idle_pulses", d, {61'd0, o.exec, o.rw, o.ill}, 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          fl[16];
        int          sel;
        fl = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h20, 'h21,
               'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
        r   = $urandom;
        sel = $urandom_range(0, 3);
        case (sel)
            0: begin r[31:26] = 6'h00; r[5:0] = 6'(fl[$urandom_range(0, 15)]); end
            1: r[31:26] = 6'h00;
            2: r[31:26] = 6'(8 + $urandom_range(0, 7));
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1);
    end

    initial begin
        obs_t o;
        rtab = '{'h00:0, 'h02:1, 'h03:2, 'h04:3, 'h06:4, 'h07:5, 'h20:6, 'h21:6,
                 'h22:7, 'h23:7, 'h24:8, 'h25:9, 'h26:10, 'h27:11, 'h2A:12, 'h2B:13};
        itab_op  = '{'h08:6, 'h09:6, 'h0A:12, 'h0B:13, 'h0C:8, 'h0D:9, 'h0E:10, 'h0F:14};
        itab_sel = '{'h08:1, 'h09:1, 'h0A:1,  'h0B:1,  'h0C:2, 'h0D:2, 'h0E:2,  'h0F:2};

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("reset_state", d, 64'(o), {16'd0, 1'b1, 47'd0});
        end
        reset = 1'b0;
        step();

        // Directed instructions
        issue(32'h00221820);   // add $3,$1,$2
        issue(32'h00052080);   // sll $4,$5,2
        issue(32'h34071234);   // ori $7,$0,0x1234
        issue(32'h8C220000);   // lw: illegal
        issue(32'h00221821);   // addu: illegal only without alias
        issue(32'h00220020);   // add $0: exec without reg_write
        issue(32'h3C1FABCD);   // lui $31
        issue(32'h2C45FFFF);   // sltiu, alias-free I-type
        issue(32'h24A60001);   // addiu: illegal only without alias

        // Reset landing in the exec cycle of addi $2,$1,-1
        instr_valid = 1'b1;
        instr       = 32'h2022FFFF;
        step();
        instr_valid = 1'b0;
        step();
        chk("rst_pre_exec", 0, {62'd0, ex0, ex1}, 64'd3);
        reset = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("rst_in_exec", d, 64'(o), {16'd0, 1'b1, 47'd0});
        end
        reset = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("rst_after", d, {62'd0, o.ready, o.rw}, 64'd2);
        end

        // Random back-to-back stream
        for (int i = 0; i < 60; i++) issue(rand_instr());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
